// File: rtl/fft_r2_stage_feeder_pkg.sv
// Shared definitions for the radix-2 streaming FFT datapath: sample format,
// twiddle-index width and the per-stage butterfly half-span.
package fft_r2_stage_feeder_pkg;

  localparam int FFT_FI_W   = 4;   // log2(NFFT), width of the twiddle index
  localparam int FFT_DATA_W = 16;  // width of each I/Q component

  typedef struct packed {
    logic [FFT_DATA_W-1:0] i;
    logic [FFT_DATA_W-1:0] q;
  } cplx_t;

  function automatic int half_span(input int size_fi, input int stage);
    return 1 << (size_fi - 1 - stage);
  endfunction

endpackage

// File: rtl/fft_pair_buffer.sv
// Half-span sample store: written during FILL, read during PAIR, both at
// butterfly index k, so a single address serves write and asynchronous read.
module fft_pair_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; every entry is written in FILL before PAIR
  // reads it, and a reset would stop the tools mapping it to distributed RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/fft_r2_stage_feeder.sv
// Feeds (x[k], x[k+H]) butterfly pairs plus the twiddle index k<<STAGE to the
// twiddle multiplier of one radix-2 streaming FFT stage.
module fft_r2_stage_feeder
  import fft_r2_stage_feeder_pkg::*;
#(
  parameter int SIZE_DATA_FI  = FFT_FI_W,
  parameter int DATA_FFT_SIZE = FFT_DATA_W,
  parameter int STAGE         = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_FFT_SIZE-1:0] in_data_i,
  input  logic [DATA_FFT_SIZE-1:0] in_data_q,
  output logic                     out_valid,
  output logic                     out_sob,
  output logic [DATA_FFT_SIZE-1:0] out_data_i,
  output logic [DATA_FFT_SIZE-1:0] out_data_q,
  output logic [DATA_FFT_SIZE-1:0] out_pair_i,
  output logic [DATA_FFT_SIZE-1:0] out_pair_q,
  output logic [SIZE_DATA_FI-1:0]  fi_deg
);

  if (STAGE < 0 || STAGE >= SIZE_DATA_FI) begin : g_bad_stage
    $error("fft_r2_stage_feeder: STAGE must be in 0..SIZE_DATA_FI-1");
  end

  localparam int H      = half_span(SIZE_DATA_FI, STAGE);
  localparam int CNT_W  = SIZE_DATA_FI - STAGE;
  localparam int ADDR_W = (CNT_W > 1) ? CNT_W - 1 : 1;

  typedef struct packed {
    logic [DATA_FFT_SIZE-1:0] i;
    logic [DATA_FFT_SIZE-1:0] q;
  } sample_t;

  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_eff;
  logic                    phase;
  logic [ADDR_W-1:0]       k;
  sample_t                 in_s, mem_rd;
  logic                    valid_q, valid_d, sob_q, sob_d;
  sample_t                 data_q, data_d, pair_q, pair_d;
  logic [SIZE_DATA_FI-1:0] fi_q, fi_d;

  assign in_s = '{i: in_data_i, q: in_data_q};

  // A start-of-frame sample restarts the block whatever the counter holds.
  assign cnt_eff = (in_valid && in_sof) ? '0 : cnt_q;
  assign phase   = cnt_eff[CNT_W-1];

  if (CNT_W > 1) begin : g_k
    assign k = cnt_eff[ADDR_W-1:0];
  end else begin : g_k_single
    assign k = '0;
  end

  fft_pair_buffer #(
    .DEPTH  (H),
    .ADDR_W (ADDR_W),
    .WIDTH  (2 * DATA_FFT_SIZE)
  ) u_buf (
    .clk     (clk),
    .we_i    (in_valid && !phase),
    .addr_i  (k),
    .wdata_i (in_s),
    .rdata_o (mem_rd)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    sob_d   = 1'b0;
    data_d  = data_q;
    pair_d  = pair_q;
    fi_d    = fi_q;
    if (in_valid) begin
      cnt_d = cnt_eff + 1'b1;
      if (phase) begin
        valid_d = 1'b1;
        sob_d   = (k == '0);
        data_d  = in_s;
        pair_d  = mem_rd;
        fi_d    = SIZE_DATA_FI'(k) << STAGE;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sob_q   <= 1'b0;
      data_q  <= '0;
      pair_q  <= '0;
      fi_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sob_q   <= sob_d;
      data_q  <= data_d;
      pair_q  <= pair_d;
      fi_q    <= fi_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_sob    = sob_q;
  assign out_data_i = data_q.i;
  assign out_data_q = data_q.q;
  assign out_pair_i = pair_q.i;
  assign out_pair_q = pair_q.q;
  assign fi_deg     = fi_q;

endmodule

// File: tb/tb_fft_r2_stage_feeder.sv
// Bench for fft_r2_stage_feeder: STAGE=0 and STAGE=2 instances share one input
// stream and are checked against a frame-position reference model and tables.
module tb_fft_r2_stage_feeder;
  import fft_r2_stage_feeder_pkg::*;

  localparam int FI_W = FFT_FI_W;
  localparam int DW   = FFT_DATA_W;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_sof;
  logic [DW-1:0] in_data_i, in_data_q;

  logic            o_valid [2];
  logic            o_sob   [2];
  logic [DW-1:0]   o_di    [2];
  logic [DW-1:0]   o_dq    [2];
  logic [DW-1:0]   o_pi    [2];
  logic [DW-1:0]   o_pq    [2];
  logic [FI_W-1:0] o_fi    [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft_r2_stage_feeder #(
      .SIZE_DATA_FI  (FI_W),
      .DATA_FFT_SIZE (DW),
      .STAGE         (2 * g)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_data_i  (in_data_i),
      .in_data_q  (in_data_q),
      .out_valid  (o_valid[g]),
      .out_sob    (o_sob[g]),
      .out_data_i (o_di[g]),
      .out_data_q (o_dq[g]),
      .out_pair_i (o_pi[g]),
      .out_pair_q (o_pq[g]),
      .fi_deg     (o_fi[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position within the 2H-sample block, plain modulo rules.
  int          hs  [2] = '{8, 2};
  int          stg [2] = '{0, 2};
  int          pos [2];
  cplx_t       mem [2][8];
  logic        e_valid [2];
  logic        e_sob   [2];
  cplx_t       e_data  [2];
  cplx_t       e_pair  [2];
  int          e_fi    [2];
  int          pulses0;

  function automatic void model(input int d, input logic rst, input logic v,
                                input logic s, input cplx_t x);
    int k;
    if (rst) begin
      pos[d] = 0; e_valid[d] = 1'b0; e_sob[d] = 1'b0;
      e_data[d] = '0; e_pair[d] = '0; e_fi[d] = 0;
      return;
    end
    e_valid[d] = 1'b0;
    e_sob[d]   = 1'b0;
    if (!v) return;
    if (s) pos[d] = 0;
    k = pos[d] % hs[d];
    if (pos[d] < hs[d]) begin
      mem[d][k] = x;
    end else begin
      e_valid[d] = 1'b1;
      e_sob[d]   = (k == 0);
      e_pair[d]  = mem[d][k];
      e_data[d]  = x;
      e_fi[d]    = k * (1 << stg[d]);
    end
    pos[d] = (pos[d] + 1) % (2 * hs[d]);
  endfunction

  task automatic step(input logic v, input logic s, input cplx_t x, input logic rst);
    reset = rst; in_valid = v; in_sof = s; in_data_i = x.i; in_data_q = x.q;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model(d, rst, v, s, x);
    #1;
    if (o_valid[0] === 1'b1) pulses0++;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("st%0d valid", stg[d]), 32'(o_valid[d]), 32'(e_valid[d]));
      check($sformatf("st%0d sob", stg[d]), 32'(o_sob[d]), 32'(e_sob[d]));
      check($sformatf("st%0d data", stg[d]), {o_di[d], o_dq[d]}, e_data[d]);
      check($sformatf("st%0d pair", stg[d]), {o_pi[d], o_pq[d]}, e_pair[d]);
      check($sformatf("st%0d fi_deg", stg[d]), 32'(o_fi[d]), 32'(e_fi[d]));
    end
  endtask

  function automatic cplx_t mk(input int n);
    cplx_t c;
    c.i = DW'(n);
    c.q = DW'(-n);
    return c;
  endfunction

  typedef struct {
    logic  v, s;
    cplx_t x;
    logic  ev, esob;
    cplx_t edata, epair;
    int    efi;
  } vec_t;

  vec_t  tbl [20];
  int    exp_pi2 [8] = '{1, 2, 5, 6, 9, 10, 13, 14};
  int    exp_di2 [8] = '{3, 4, 7, 8, 11, 12, 15, 16};
  int    got_pi2 [8];
  int    got_di2 [8];
  int    got_fi2 [8];
  logic  got_sb2 [8];
  int    n2;
  cplx_t z;

  initial begin
    z = '0;
    for (int c = 0; c < 20; c++) begin
      int k;
      k = c - 8;
      tbl[c].v    = (c < 16);
      tbl[c].s    = (c == 0);
      tbl[c].x    = (c < 16) ? mk(c + 1) : z;
      tbl[c].ev   = (c >= 8 && c < 16);
      tbl[c].esob = (c == 8);
      if (c < 8) begin
        tbl[c].edata = z; tbl[c].epair = z; tbl[c].efi = 0;
      end else if (c < 16) begin
        tbl[c].edata = mk(k + 9); tbl[c].epair = mk(k + 1); tbl[c].efi = k;
      end else begin
        tbl[c].edata = mk(16); tbl[c].epair = mk(8); tbl[c].efi = 7;
      end
    end

    // Reset state
    step(1'b1, 1'b1, mk(77), 1'b1);
    step(1'b1, 1'b0, mk(78), 1'b1);
    check("reset valid", 32'(o_valid[0]), 32'd0);
    check("reset data", {o_di[0], o_dq[0], o_fi[0]}, '0);

    // Back-to-back frame, STAGE=0 from table, STAGE=2 collected and compared
    n2 = 0;
    for (int c = 0; c < 20; c++) begin
      step(tbl[c].v, tbl[c].s, tbl[c].x, 1'b0);
      check($sformatf("tbl%0d valid", c), 32'(o_valid[0]), 32'(tbl[c].ev));
      if (tbl[c].ev) check($sformatf("tbl%0d sob", c), 32'(o_sob[0]), 32'(tbl[c].esob));
      check($sformatf("tbl%0d data", c), {o_di[0], o_dq[0]}, tbl[c].edata);
      check($sformatf("tbl%0d pair", c), {o_pi[0], o_pq[0]}, tbl[c].epair);
      check($sformatf("tbl%0d fi", c), 32'(o_fi[0]), 32'(tbl[c].efi));
      if (o_valid[1] === 1'b1) begin
        if (n2 < 8) begin
          got_pi2[n2] = int'(o_pi[1]); got_di2[n2] = int'(o_di[1]);
          got_fi2[n2] = int'(o_fi[1]); got_sb2[n2] = o_sob[1];
        end
        n2++;
      end
    end
    check("st2 pair count", 32'(n2), 32'd8);
    for (int p = 0; p < 8 && p < n2; p++) begin
      check($sformatf("st2 tbl pair%0d", p), 32'(got_pi2[p]), 32'(exp_pi2[p]));
      check($sformatf("st2 tbl data%0d", p), 32'(got_di2[p]), 32'(exp_di2[p]));
      check($sformatf("st2 tbl fi%0d", p), 32'(got_fi2[p]), 32'((p % 2) * 4));
      check($sformatf("st2 tbl sob%0d", p), 32'(got_sb2[p]), 32'(p % 2 == 0));
    end

    // Gapped input: in_valid low every other cycle
    pulses0 = 0;
    for (int n = 0; n < 16; n++) begin
      step(1'b1, n == 0, mk(n + 1), 1'b0);
      step(1'b0, 1'b0, mk(999), 1'b0);
      check("gap valid low", 32'(o_valid[0]), 32'd0);
    end
    check("gap pulses", 32'(pulses0), 32'd8);

    // Abandoned 5-sample block, then a fresh in_sof frame
    pulses0 = 0;
    for (int n = 0; n < 5; n++) step(1'b1, n == 0, mk(100 + n), 1'b0);
    check("abandon no pulses", 32'(pulses0), 32'd0);
    for (int n = 0; n < 16; n++) step(1'b1, n == 0, mk(200 + n), 1'b0);
    check("restart pulses", 32'(pulses0), 32'd8);

    // Reset after the 11th sample (mid-PAIR), then a frame without in_sof
    for (int n = 0; n < 11; n++) step(1'b1, n == 0, mk(300 + n), 1'b0);
    step(1'b1, 1'b0, mk(311), 1'b1);
    check("midrst valid", 32'(o_valid[0]), 32'd0);
    check("midrst data", {o_di[0], o_dq[0]}, '0);
    check("midrst pair", {o_pi[0], o_pq[0]}, '0);
    check("midrst fi", 32'(o_fi[0]), 32'd0);
    pulses0 = 0;
    for (int n = 0; n < 16; n++) step(1'b1, 1'b0, mk(400 + n), 1'b0);
    check("post-reset pulses", 32'(pulses0), 32'd8);

    // in_sof held high without in_valid mid-block
    pulses0 = 0;
    for (int n = 0; n < 5; n++) step(1'b1, n == 0, mk(500 + n), 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, mk(600), 1'b0);
    for (int n = 5; n < 16; n++) step(1'b1, 1'b0, mk(500 + n), 1'b0);
    check("sof idle pulses", 32'(pulses0), 32'd8);

    // Randomised traffic with occasional in_sof and reset
    for (int n = 0; n < 600; n++) begin
      cplx_t x;
      logic  v;
      x.i = DW'($urandom);
      x.q = DW'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      step(v, $urandom_range(0, 24) == 0, x, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_r2_stage_feeder.md
Name: fft_r2_stage_feeder

Overview:
Upstream feeder for the twiddle multiplier stage of the radix-2 streaming FFT. It takes one complex sample per valid cycle and buffers the first half-span of each butterfly block. It then emits butterfly pairs (x[k], x[k+H]) together with the twiddle index fi_deg for k. The outputs connect directly to the multiplier's en / in_data_i / in_data_q / fi_deg inputs. The partner sample is passed alongside for the butterfly adder.

Parameters:
SIZE_DATA_FI, 4, log2(NFFT); width of fi_deg.
DATA_FFT_SIZE, 16, width of each I/Q component (two's complement).
STAGE, 0, FFT stage index, 0..SIZE_DATA_FI-1. Half-span H = 2^(SIZE_DATA_FI-1-STAGE).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_sof  in  1  first sample of a frame; qualified by in_valid.
in_data_i  in  DATA_FFT_SIZE  input real part.
in_data_q  in  DATA_FFT_SIZE  input imaginary part.
out_valid  out  1  pair valid; drives multiplier en.
out_sob  out  1  first pair of a butterfly block (k==0).
out_data_i  out  DATA_FFT_SIZE  x[k+H] real part, to the multiplier.
out_data_q  out  DATA_FFT_SIZE  x[k+H] imaginary part.
out_pair_i  out  DATA_FFT_SIZE  x[k] real part, to the butterfly adder.
out_pair_q  out  DATA_FFT_SIZE  x[k] imaginary part.
fi_deg  out  SIZE_DATA_FI  twiddle index = k << STAGE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Counter: cnt, width SIZE_DATA_FI-STAGE. k = cnt low bits; phase = cnt MSB.
  - Advances only on in_valid.
  - Wraps from 2H-1 to 0.
- Buffer: H entries of {i,q}, addressed by k. No reset on contents.
- Phase 0 (FILL), accepted sample: mem[k] <= sample; no output.
- Phase 1 (PAIR), accepted sample, on the next cycle:
  - out_valid=1.
  - out_pair = mem[k].
  - out_data = incoming sample.
  - fi_deg = k<<STAGE.
  - out_sob = (k==0).
- Latency: 1 cycle from acceptance of x[k+H] to out_valid.
- Gaps: in_valid=0 holds cnt; out_valid=0 next cycle. Data outputs hold their last value.
- in_sof with in_valid: the sample is treated as cnt=0 (FILL, k=0) whatever the current cnt.
  - Any partially filled or partially drained block is abandoned; no pairs are emitted for it.
  - cnt becomes 1 after this sample.
- in_sof without in_valid: ignored.
- Reset, synchronous, also mid-block:
  - cnt=0, out_valid=0, out_sob=0, all data outputs and fi_deg = 0.
  - Partial block discarded.
  - Applies on the first cycle after reset is sampled high; inputs are ignored while reset=1.
- Width rules: no arithmetic on data; samples pass bit-exact. fi_deg max = NFFT/2 - 2^STAGE, which always fits.
- STAGE >= SIZE_DATA_FI is illegal: elaboration-time error.
- Throughput: one sample per cycle sustained; no backpressure. The consumer must accept every out_valid.

Decomposition:
- Shared FFT package holds:
  - complex-sample struct {i,q} of DATA_FFT_SIZE;
  - function half_span(SIZE_DATA_FI, STAGE);
  - twiddle-index width constant.
- One natural sub-module: fft_pair_buffer. It is an H-deep simple dual-port RAM (write in FILL, read in PAIR, same address k) and maps to distributed RAM.
- Counter, phase logic and output registers stay in the top level.

Test Plan:
- NFFT=16, STAGE=0 (H=8); 16 back-to-back samples, in_sof on the first, x[n]=(n+1, -(n+1)), n=0..15.
  - Expect 8 consecutive out_valid cycles starting 1 cycle after n=8 is accepted.
  - Pair k: out_pair=(k+1, -(k+1)), out_data=(k+9, -(k+9)), fi_deg=k for k=0..7.
  - out_sob only at k=0.
- STAGE=2 (H=2), same 16 samples.
  - Pairs (1,3),(2,4),(5,7),(6,8),(9,11),(10,12),(13,15),(14,16), with fi_deg alternating 0,4.
  - out_sob on every first pair of each block.
- STAGE=0 with in_valid low every other cycle.
  - Identical pair sequence to the first test; out_valid pulses singly, 1 cycle after each PAIR-phase sample.
  - cnt does not advance in the gaps.
- STAGE=0; send 5 samples, then a new in_sof frame of 16 samples.
  - No output from the first 5 samples.
  - The new frame yields exactly 8 pairs whose values are from the new frame only.
- Assert reset for 1 cycle after the 11th sample (mid-PAIR).
  - Next cycle out_valid=0 and outputs are 0.
  - A following 16-sample frame with no in_sof still starts at cnt=0 and yields the correct 8 pairs.
- Hold in_sof=1 with in_valid=0 for several cycles mid-block: no effect on cnt or outputs.
